// File: rtl/q2.sv
// q2: 12-bit accumulator CPU with a front-panel switch interface.
// Drives an external 4096-word memory over abus/dbus with rdm/wrm strobes.
module q2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw,
  inout  wire  [11:0] dbus,
  output logic [11:0] abus,
  output logic        wrm,
  output logic        rdm,
  input  logic        incp_sw,
  input  logic        dep_sw,
  input  logic        start_sw,
  input  logic        stop_sw,
  output logic        run
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IND, S_EXEC, S_WSET, S_WSTB, S_DSET, S_DSTB
  } state_t;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_ST  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JZ  = 3'd5;
  localparam logic [2:0] OP_JSR = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  logic [11:0] r_p, r_a, r_ir, r_ea;
  logic        r_run, r_incp_q, r_dep_q;
  state_t      r_state, w_state, w_next;

  logic [2:0]  w_op;
  logic        w_ind, w_halt, w_skip, w_drive;
  logic        w_incp_rise, w_dep_rise, w_is_store;
  logic [11:0] w_direct, w_opr_a, w_dout;

  assign run         = r_run;
  assign w_op        = r_ir[11:9];
  assign w_ind       = r_ir[8];
  assign w_direct    = {(r_ir[7] ? r_p[11:7] : 5'b0), r_ir[6:0]};
  assign w_is_store  = (w_op == OP_ST) || (w_op == OP_JSR);
  assign w_incp_rise = incp_sw & ~r_incp_q;
  assign w_dep_rise  = dep_sw & ~r_dep_q;
  assign w_halt      = (w_state == S_DECODE) && (w_op == OP_OPR) && r_ir[0];

  // Run latch reacts to the switches without a clock; HLT clears it on the edge.
  always_ff @(posedge clk or posedge rst or posedge stop_sw or posedge start_sw) begin
    if (rst || stop_sw)  r_run <= 1'b0;
    else if (start_sw)   r_run <= 1'b1;
    else if (w_halt)     r_run <= 1'b0;
  end

  // Dropping run abandons any instruction at once; panel deposits run with run low.
  always_comb begin
    w_state = r_state;
    if (!r_run && (r_state != S_DSET) && (r_state != S_DSTB)) w_state = S_IDLE;
  end

  // NOTE: blocking assignments here chain the micro-ops in order within one evaluation.
  always_comb begin
    w_opr_a = r_a;
    if (r_ir[1]) w_opr_a = 12'h000;
    if (r_ir[2]) w_opr_a = ~w_opr_a;
    if (r_ir[3]) w_opr_a = w_opr_a + 12'd1;
    if (r_ir[4]) w_opr_a = {w_opr_a[10:0], 1'b0};
    if (r_ir[5]) w_opr_a = {1'b0, w_opr_a[11:1]};
    w_skip = (r_ir[6] && (w_opr_a == 12'h000)) || (r_ir[7] && w_opr_a[11]);
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_next = w_state;
    case (w_state)
      S_IDLE:   if (r_run) w_next = S_FETCH;
                else if (w_dep_rise) w_next = S_DSET;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_OPR)                          w_next = w_halt ? S_IDLE : S_FETCH;
        else if (w_ind)                              w_next = S_IND;
        else if ((w_op == OP_JMP) || (w_op == OP_JZ)) w_next = S_FETCH;
        else if (w_is_store)                         w_next = S_WSET;
        else                                         w_next = S_EXEC;
      end
      S_IND:    w_next = w_is_store ? S_WSET : S_EXEC;
      S_EXEC:   w_next = S_FETCH;
      S_WSET:   w_next = S_WSTB;
      S_WSTB:   w_next = S_FETCH;
      S_DSET:   w_next = S_DSTB;
      S_DSTB:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    abus    = r_p;
    rdm     = 1'b0;
    wrm     = 1'b0;
    w_drive = 1'b0;
    w_dout  = (w_op == OP_JSR) ? r_p : r_a;
    case (w_state)
      S_FETCH: rdm = 1'b1;
      S_IND:   begin abus = r_ea; rdm = 1'b1; end
      S_EXEC:  begin
        abus = r_ea;
        rdm  = (w_op == OP_LD) || (w_op == OP_ADD) || (w_op == OP_AND);
      end
      S_WSET:  begin abus = r_ea; w_drive = 1'b1; end
      S_WSTB:  begin abus = r_ea; w_drive = 1'b1; wrm = 1'b1; end
      // During a deposit EA holds the switch value captured at the press.
      S_DSET:  begin w_dout = r_ea; w_drive = 1'b1; end
      S_DSTB:  begin w_dout = r_ea; w_drive = 1'b1; wrm = 1'b1; end
      default: ;
    endcase
  end

  assign dbus = w_drive ? w_dout : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p      <= 12'h000;
      r_a      <= 12'h000;
      r_ir     <= 12'h000;
      r_ea     <= 12'h000;
      r_incp_q <= 1'b0;
      r_dep_q  <= 1'b0;
    end else begin
      r_incp_q <= incp_sw;
      r_dep_q  <= dep_sw;
      case (w_state)
        S_IDLE: if (!r_run) begin
          if (w_dep_rise)       r_ea <= sw;
          else if (w_incp_rise) r_p  <= r_p + 12'd1;
        end
        S_FETCH: begin
          r_ir <= dbus;
          r_p  <= r_p + 12'd1;
        end
        S_DECODE: begin
          if (w_op == OP_OPR) begin
            r_a <= w_opr_a;
            if (w_skip) r_p <= r_p + 12'd1;
          end else begin
            r_ea <= w_direct;
            if (!w_ind && (w_op == OP_JMP)) r_p <= w_direct;
            if (!w_ind && (w_op == OP_JZ) && (r_a == 12'h000)) r_p <= w_direct;
          end
        end
        S_IND: r_ea <= dbus;
        S_EXEC: begin
          case (w_op)
            OP_LD:   r_a <= dbus;
            OP_ADD:  r_a <= r_a + dbus;
            OP_AND:  r_a <= r_a & dbus;
            OP_JMP:  r_p <= r_ea;
            OP_JZ:   if (r_a == 12'h000) r_p <= r_ea;
            default: ;
          endcase
        end
        S_WSTB: if (w_op == OP_JSR) r_p <= r_ea + 12'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q2.sv
// Directed bench for q2: behavioural memory with I/O at 0xFFF, hand-computed expectations.
module tb_q2;

  logic        clk, rst;
  logic [11:0] sw;
  wire  [11:0] dbus;
  logic [11:0] abus;
  logic        wrm, rdm, run;
  logic        incp_sw, dep_sw, start_sw, stop_sw;

  logic [11:0] mem [4096];
  logic [11:0] key_n, disp, prev_abus, prev_dbus;
  int          n_pass, n_total, n_fail, wr_fff_cnt, n_unstable, n_overlap, cyc;

  q2 dut (
    .clk(clk), .rst(rst), .sw(sw), .dbus(dbus), .abus(abus), .wrm(wrm), .rdm(rdm),
    .incp_sw(incp_sw), .dep_sw(dep_sw), .start_sw(start_sw), .stop_sw(stop_sw), .run(run)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dbus = rdm ? ((abus == 12'hFFF) ? key_n : mem[abus]) : 'z;

  always @(posedge wrm) begin
    if ((prev_abus != abus) || (prev_dbus != dbus)) n_unstable++;
    if (abus == 12'hFFF) begin
      disp = dbus;
      wr_fff_cnt++;
    end else begin
      mem[abus] = dbus;
    end
  end

  always @(negedge clk) begin
    prev_abus = abus;
    prev_dbus = dbus;
    if (rdm && wrm) n_overlap++;
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_sw = 1'b1;
    #1 start_sw = 1'b0;
  endtask

  task automatic wait_halt(output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1 c++;
    end while (run && (c < 200));
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    wr_fff_cnt = 0; n_unstable = 0; n_overlap = 0;
    disp = 12'h000; key_n = 12'hFFB;
    rst = 1'b1; sw = 12'h000;
    incp_sw = 1'b0; dep_sw = 1'b0; start_sw = 1'b0; stop_sw = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'h000;

    // Program image
    mem[12'h000] = 12'h010; mem[12'h001] = 12'h411; mem[12'h002] = 12'h212; mem[12'h003] = 12'hE01;
    mem[12'h010] = 12'h7FF; mem[12'h011] = 12'h001;
    mem[12'h004] = 12'h021; mem[12'h005] = 12'h320; mem[12'h006] = 12'hE01;
    mem[12'h020] = 12'hFFF; mem[12'h021] = 12'h141;
    mem[12'h007] = 12'h120; mem[12'h008] = 12'hE05;
    mem[12'h009] = 12'h260; mem[12'h00A] = 12'hE01;
    mem[12'h00B] = 12'hC30; mem[12'h031] = 12'hE03;
    mem[12'h032] = 12'hA40; mem[12'h040] = 12'hE09;
    mem[12'h041] = 12'hA50; mem[12'h042] = 12'hE03;
    mem[12'h043] = 12'hE41; mem[12'h044] = 12'hE01;
    mem[12'h045] = 12'hE85; mem[12'h046] = 12'hE01;
    mem[12'h047] = 12'hE30; mem[12'h048] = 12'h261; mem[12'h049] = 12'hE01;

    #2;
    check("reset_run", {11'b0, run}, 12'h000);
    check("reset_rdm", {11'b0, rdm}, 12'h000);
    check("reset_wrm", {11'b0, wrm}, 12'h000);
    check("reset_abus", abus, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_abus_after_reset", abus, 12'h000);

    // Start without any clock edge, then the first clock fetches from 0
    start_sw = 1'b1;
    #1;
    check("run_async_set", {11'b0, run}, 12'h001);
    start_sw = 1'b0;
    #1;
    check("run_held_after_start", {11'b0, run}, 12'h001);
    @(posedge clk);
    #1;
    check("first_fetch_rdm", {11'b0, rdm}, 12'h001);
    check("first_fetch_abus", abus, 12'h000);
    cyc = 1;
    while (run && (cyc < 200)) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("prog1_cycles", cyc[11:0], 12'd13);
    check("prog1_add_wrap_store", mem[12'h012], 12'h800);
    check("prog1_halt_p", abus, 12'h004);

    // Indirect store to the display
    pulse_start();
    wait_halt(cyc);
    check("out_cycles", cyc[11:0], 12'd11);
    check("out_display", disp, 12'h141);
    check("out_write_count", wr_fff_cnt[11:0], 12'd1);
    check("out_write_stable", n_unstable[11:0], 12'd0);
    check("out_halt_p", abus, 12'h007);

    // Indirect key read, then CMA+HLT; result observed through a store
    pulse_start();
    wait_halt(cyc);
    check("key_cycles", cyc[11:0], 12'd7);
    check("key_halt_p", abus, 12'h009);
    pulse_start();
    wait_halt(cyc);
    check("key_cma_result", mem[12'h060], 12'h004);
    check("key_store_halt_p", abus, 12'h00B);

    // JSR, then CLA+HLT
    pulse_start();
    wait_halt(cyc);
    check("jsr_cycles", cyc[11:0], 12'd7);
    check("jsr_return_addr", mem[12'h030], 12'h00C);
    check("jsr_halt_p", abus, 12'h032);

    // JZ taken with A=0 (lands at 0x40: INC+HLT)
    pulse_start();
    wait_halt(cyc);
    check("jz_taken_cycles", cyc[11:0], 12'd5);
    check("jz_taken_p", abus, 12'h041);

    // JZ not taken with A=1
    pulse_start();
    wait_halt(cyc);
    check("jz_not_taken_p", abus, 12'h043);

    // Skip on zero with A=0
    pulse_start();
    wait_halt(cyc);
    check("opr_skip_cycles", cyc[11:0], 12'd3);
    check("opr_skip_zero_p", abus, 12'h045);

    // CMA then skip on A[11]
    pulse_start();
    wait_halt(cyc);
    check("opr_skip_msb_p", abus, 12'h047);

    // SHL then SHR of 0xFFF, stored to 0x61
    pulse_start();
    wait_halt(cyc);
    check("shift_cycles", cyc[11:0], 12'd9);
    check("shift_result", mem[12'h061], 12'h7FF);
    check("shift_halt_p", abus, 12'h04A);

    // Front panel deposit and increment with run low
    sw = 12'h800;
    @(negedge clk); dep_sw = 1'b1;
    repeat (3) @(negedge clk);
    dep_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("deposit_data", mem[12'h04A], 12'h800);
    check("deposit_keeps_p", abus, 12'h04A);
    incp_sw = 1'b1;
    repeat (3) @(negedge clk);
    incp_sw = 1'b0;
    repeat (2) @(negedge clk);
    check("incp_one_step", abus, 12'h04B);

    // Stop during the write strobe of a direct ST
    mem[12'h04B] = 12'h262;
    mem[12'h04C] = 12'h010;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    check("stop_wr_wrm_high", {11'b0, wrm}, 12'h001);
    check("stop_wr_abus", abus, 12'h062);
    stop_sw = 1'b1;
    #1;
    check("stop_wr_run", {11'b0, run}, 12'h000);
    check("stop_wr_wrm_low", {11'b0, wrm}, 12'h000);
    check("stop_wr_idle_abus", abus, 12'h04C);
    stop_sw = 1'b0;
    @(posedge clk);
    #1;
    check("stop_wr_p_kept", abus, 12'h04C);

    // Stop during a fetch
    pulse_start();
    @(posedge clk);
    #1;
    check("stop_rd_rdm_high", {11'b0, rdm}, 12'h001);
    stop_sw = 1'b1;
    #1;
    check("stop_rd_run", {11'b0, run}, 12'h000);
    check("stop_rd_rdm_low", {11'b0, rdm}, 12'h000);
    stop_sw = 1'b0;
    @(posedge clk);
    #1;
    check("stop_rd_p_kept", abus, 12'h04C);

    check("never_rdm_and_wrm", n_overlap[11:0], 12'd0);
    check("all_writes_stable", n_unstable[11:0], 12'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
